hwpe_stream_tcdm_responder: RTL and testbench

// - TCDM slave endpoint: answers requests from a TCDM master port, backed by a word-addressed register-file memory.
// - Stands in for cluster TCDM in HWPE block-level benches; also serves as a small scratchpad in integration.
// - Grant latency and stalls are programmable, so masters are exercised under backpressure.
// - Reads return r_valid/r_data exactly one cycle after the read handshake.

---
 rtl/hwpe_stream_tcdm_responder_if.sv | 26 ++
 rtl/hwpe_stream_tcdm_responder.sv | 165 ++++++++++++++++
 tb/tb_hwpe_stream_tcdm_responder.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_responder_if.sv
// ---------------------------------------------------------------------------
// hwpe_stream_intf_tcdm
// Single-port TCDM bus: request channel (req/add/wen/be/data) from the master,
// grant and one-cycle-late read response (gnt/r_data/r_valid) from the slave.
//   req      master -> slave  request valid
//   add      master -> slave  byte address
//   wen      master -> slave  1 = read, 0 = write
//   be       master -> slave  byte enables for writes
//   data     master -> slave  write data
//   gnt      slave -> master  request accepted this cycle
//   r_data   slave -> master  read data
//   r_valid  slave -> master  r_data valid
// ---------------------------------------------------------------------------
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_responder.sv
// ---------------------------------------------------------------------------
// hwpe_stream_tcdm_responder
// TCDM slave endpoint backed by a word-addressed register-file memory. Grants
// after a programmable number of wait cycles so masters see backpressure;
// read data comes back exactly one cycle after the read handshake.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active-high (clears memory too)
//   clear_i      synchronous clear of control state, memory kept
//   enable_i     0 = never grant
//   tcdm         TCDM slave port (hwpe_stream_intf_tcdm.slave)
//   nb_reads_o   granted reads since reset/clear (wraps)
//   nb_writes_o  granted writes since reset/clear (wraps)
//   oor_err_o    sticky flag: an out-of-range access was granted
//
// Optional feature: define HWPE_TCDM_RESPONDER_RANDOM_STALL_EN to add a
// 16-bit LFSR that randomly masks gnt (about one cycle in four).
// ---------------------------------------------------------------------------
module hwpe_stream_tcdm_responder #(
    parameter int unsigned NB_WORDS    = 1024,
    parameter int unsigned GNT_LATENCY = 0,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter logic [31:0] OOR_RDATA   = 32'hDEADBEEF,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    hwpe_stream_intf_tcdm.slave  tcdm,
    output logic [CNT_WIDTH-1:0] nb_reads_o,
    output logic [CNT_WIDTH-1:0] nb_writes_o,
    output logic                 oor_err_o
);

    localparam int unsigned AW  = $clog2(NB_WORDS);
    // Wait counter must hold 0..GNT_LATENCY; keep at least one bit.
    localparam int unsigned WCW = (GNT_LATENCY > 0) ? $clog2(GNT_LATENCY + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(GNT_LATENCY);

    logic [31:0]          r_mem [NB_WORDS];
    logic [WCW-1:0]       r_wait_cnt;
    logic [WCW-1:0]       w_wait_cnt_next;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic [CNT_WIDTH-1:0] r_nb_reads;
    logic [CNT_WIDTH-1:0] r_nb_writes;
    logic                 r_oor_err;

    logic                 w_rnd_stall;
    logic                 w_gnt;
    logic                 w_hs;
    logic                 w_rd_hs;
    logic                 w_wr_hs;
    logic                 w_oor;
    logic                 w_mem_we;
    logic [AW-1:0]        w_idx;
    logic                 w_unused;

`ifdef HWPE_TCDM_RESPONDER_RANDOM_STALL_EN
    // Fibonacci LFSR, taps 16,14,13,11; free-running regardless of req.
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr <= LFSR_SEED;
        end else if (clear_i) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_rnd_stall = (r_lfsr[1:0] == 2'b00);
    assign w_unused    = ^tcdm.add[1:0];
`else
    assign w_rnd_stall = 1'b0;
    assign w_unused    = ^{tcdm.add[1:0], LFSR_SEED};
`endif

    // Address decode: word index from the byte address, range check on the
    // full word address so aliases above the memory are flagged, not wrapped.
    assign w_idx = tcdm.add[2 +: AW];
    assign w_oor = (tcdm.add[31:2] >= 30'(NB_WORDS));

    assign w_gnt    = tcdm.req & enable_i & (r_wait_cnt == WAIT_MAX) & ~w_rnd_stall;
    assign w_hs     = tcdm.req & w_gnt;
    assign w_rd_hs  = w_hs &  tcdm.wen;
    assign w_wr_hs  = w_hs & ~tcdm.wen;
    assign w_mem_we = w_wr_hs & ~w_oor;

    // Wait counter: restarts on every handshake or idle cycle, freezes while
    // disabled, saturates at GNT_LATENCY (a random stall keeps it saturated).
    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if (!tcdm.req || w_hs) begin
            w_wait_cnt_next = '0;
        end else if (enable_i && (r_wait_cnt != WAIT_MAX)) begin
            w_wait_cnt_next = r_wait_cnt + WCW'(1);
        end
    end

    // Control state. clear_i has priority over a same-cycle handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait_cnt  <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_nb_reads  <= '0;
            r_nb_writes <= '0;
            r_oor_err   <= 1'b0;
        end else if (clear_i) begin
            r_wait_cnt  <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_nb_reads  <= '0;
            r_nb_writes <= '0;
            r_oor_err   <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
            r_rvalid   <= w_rd_hs;
            if (w_rd_hs) begin
                r_rdata    <= w_oor ? OOR_RDATA : r_mem[w_idx];
                r_nb_reads <= r_nb_reads + CNT_WIDTH'(1);
            end
            if (w_wr_hs) begin
                r_nb_writes <= r_nb_writes + CNT_WIDTH'(1);
            end
            if (w_hs && w_oor) begin
                r_oor_err <= 1'b1;
            end
        end
    end

    // Register-file memory: one process per word so every word resets to
    // zero; byte-lane writes under be.
    generate
        for (genvar gi = 0; gi < NB_WORDS; gi++) begin : g_word
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_mem[gi] <= '0;
                end else if (w_mem_we && (w_idx == AW'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (tcdm.be[b]) begin
                            r_mem[gi][8*b +: 8] <= tcdm.data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    assign tcdm.gnt     = w_gnt;
    // A clear in the response cycle drops the pending r_valid immediately.
    assign tcdm.r_valid = r_rvalid & ~clear_i;
    assign tcdm.r_data  = r_rdata;
    assign nb_reads_o   = r_nb_reads;
    assign nb_writes_o  = r_nb_writes;
    assign oor_err_o    = r_oor_err;

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// ---------------------------------------------------------------------------
// Bench for hwpe_stream_tcdm_responder. Two instances (GNT_LATENCY 0 and 3)
// share one stimulus bus; sel routes req to one of them and muxes outputs.
// The driver pushes expected read data into a queue at each read grant; a
// monitor on the falling edge checks r_valid timing, r_data and hold value.
// ---------------------------------------------------------------------------
module tb_hwpe_stream_tcdm_responder;

    localparam int          NBW     = 1024;
    localparam logic [31:0] OOR_VAL = 32'hDEADBEEF;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        clear  = 1'b0;
    logic        enable = 1'b1;
    logic        sel    = 1'b0;
    logic        req    = 1'b0;
    logic        wen    = 1'b0;
    logic [31:0] add    = '0;
    logic [31:0] wdata  = '0;
    logic [3:0]  be     = '0;

    logic [31:0] nbr0, nbw0, nbr3, nbw3;
    logic        oor0, oor3;

    always #5 clk = ~clk;

    hwpe_stream_intf_tcdm tcdm0 ();
    hwpe_stream_intf_tcdm tcdm3 ();

    assign tcdm0.req  = req & ~sel;
    assign tcdm0.add  = add;
    assign tcdm0.wen  = wen;
    assign tcdm0.be   = be;
    assign tcdm0.data = wdata;
    assign tcdm3.req  = req & sel;
    assign tcdm3.add  = add;
    assign tcdm3.wen  = wen;
    assign tcdm3.be   = be;
    assign tcdm3.data = wdata;

    hwpe_stream_tcdm_responder #(.NB_WORDS(NBW), .GNT_LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
        .tcdm(tcdm0), .nb_reads_o(nbr0), .nb_writes_o(nbw0), .oor_err_o(oor0)
    );

    hwpe_stream_tcdm_responder #(.NB_WORDS(NBW), .GNT_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
        .tcdm(tcdm3), .nb_reads_o(nbr3), .nb_writes_o(nbw3), .oor_err_o(oor3)
    );

    logic        gnt_s, rv_s, oor_s;
    logic [31:0] rd_s, nbr_s, nbw_s;
    assign gnt_s = sel ? tcdm3.gnt     : tcdm0.gnt;
    assign rv_s  = sel ? tcdm3.r_valid : tcdm0.r_valid;
    assign rd_s  = sel ? tcdm3.r_data  : tcdm0.r_data;
    assign nbr_s = sel ? nbr3 : nbr0;
    assign nbw_s = sel ? nbw3 : nbw0;
    assign oor_s = sel ? oor3 : oor0;

    // Reference model: plain memory image and counters per instance.
    logic [31:0] mdl_mem [2][NBW];
    int unsigned mdl_rd  [2];
    int unsigned mdl_wr  [2];
    logic        mdl_oor [2];
    logic [31:0] exp_q [$];

    int checks    = 0;
    int errors    = 0;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return (a >> 2) >= NBW;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NBW; i++) mdl_mem[s][i] = '0;
            mdl_rd[s] = 0; mdl_wr[s] = 0; mdl_oor[s] = 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            mdl_rd[s] = 0; mdl_wr[s] = 0; mdl_oor[s] = 1'b0;
        end
    endtask

    // Applied at the falling edge before the handshake edge.
    task automatic model_apply(input bit is_rd, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b);
        int s   = sel ? 1 : 0;
        int idx = int'((a >> 2) % NBW);
        if (is_oor(a)) mdl_oor[s] = 1'b1;
        if (is_rd) begin
            mdl_rd[s]++;
            exp_q.push_back(is_oor(a) ? OOR_VAL : mdl_mem[s][idx]);
        end else begin
            mdl_wr[s]++;
            if (!is_oor(a)) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mdl_mem[s][idx][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    // Monitor: a read granted at edge N must show r_valid with the expected
    // data between edges N and N+1; otherwise r_valid=0 and r_data holds.
    bit          pend = 1'b0;
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    logic [31:0] mon_e;

    always @(negedge clk) begin
        if (rst || clear) begin
            chk("rvalid_in_rst_clr", {31'b0, rv_s}, 32'h0);
            exp_q.delete();
            pend = 1'b0;
            last_rd[0] = '0;
            last_rd[1] = '0;
        end else begin
            if (pend) begin
                chk("rvalid_after_read", {31'b0, rv_s}, 32'h1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: got r_valid with no expected entry at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rdata", rd_s, mon_e);
                    last_rd[sel] = mon_e;
                    $display("read  sel=%0d data=0x%08h exp=0x%08h", sel, rd_s, mon_e);
                end
            end else begin
                chk("rvalid_idle", {31'b0, rv_s}, 32'h0);
                chk("rdata_hold", rd_s, last_rd[sel]);
            end
            pend = req & gnt_s & wen;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus transaction. Starts just after a rising edge; returns just after
    // the handshake edge with req low. off_mask[k] forces enable low in wait
    // cycle k; rnd_en instead randomises enable every cycle.
    task automatic access(input bit is_rd, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit rnd_en, input logic [7:0] off_mask,
                          output int waits);
        int k    = 0;
        bit done = 1'b0;
        req = 1'b1; wen = is_rd; add = a; wdata = d; be = b; waits = 0;
        enable = rnd_en ? ($urandom_range(0, 3) != 0) : ~off_mask[0];
        while (!done) begin
            @(negedge clk);
            if (gnt_s) begin
                done = 1'b1;
                model_apply(is_rd, a, d, b);
            end else begin
                if (!sel && enable) stall_cnt++;
                waits++;
                if (waits > 200) begin
                    checks++; errors++;
                    $display("FAIL gnt_timeout: no gnt after %0d cycles, add=0x%08h", waits, a);
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    k++;
                    enable = rnd_en ? ($urandom_range(0, 3) != 0) : ((k < 8) ? ~off_mask[k] : 1'b1);
                end
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
        enable = 1'b1;
        if (!is_rd) $display("write sel=%0d add=0x%08h data=0x%08h be=%h waits=%0d", sel, a, d, b, waits);
    endtask

    task automatic check_counts(input string tag);
        int s = sel ? 1 : 0;
        chk({tag, "_nb_reads"},  nbr_s, mdl_rd[s]);
        chk({tag, "_nb_writes"}, nbw_s, mdl_wr[s]);
        chk({tag, "_oor_err"},   {31'b0, oor_s}, {31'b0, mdl_oor[s]});
    endtask

    task automatic rand_phase(input int n);
        int unsigned idx;
        int          r, w;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 85)      idx = $urandom_range(0, 31);
            else if (r < 93) idx = $urandom_range(0, NBW - 1);
            else             idx = $urandom_range(NBW, 32'h3FFF_FFFF);
            a = (idx << 2) | $urandom_range(0, 3);
            access($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), 1'b1, 8'h00, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        model_reset();
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state of both instances.
        chk("rst_nbr0", nbr0, 0); chk("rst_nbw0", nbw0, 0); chk("rst_oor0", {31'b0, oor0}, 0);
        chk("rst_nbr3", nbr3, 0); chk("rst_nbw3", nbw3, 0); chk("rst_oor3", {31'b0, oor3}, 0);

        // GNT_LATENCY=0: combinational grant, basic write/read.
        sel = 1'b0;
        access(1'b0, 32'h10, 32'hCAFEBABE, 4'hF, 1'b0, 8'h00, w);
`ifndef HWPE_TCDM_RESPONDER_RANDOM_STALL_EN
        chk("lat0_write_waits", w, 0);
`endif
        access(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 8'h00, w);
`ifndef HWPE_TCDM_RESPONDER_RANDOM_STALL_EN
        chk("lat0_read_waits", w, 0);
`endif
        check_counts("basic");

        // Byte enables.
        access(1'b0, 32'h0C, 32'h11223344, 4'hF, 1'b0, 8'h00, w);
        access(1'b0, 32'h0C, 32'hAABBCCDD, 4'b0101, 1'b0, 8'h00, w);
        access(1'b1, 32'h0E, 32'h0, 4'h0, 1'b0, 8'h00, w);
        // be=0 write is a counted no-op.
        access(1'b0, 32'h0C, 32'hFFFFFFFF, 4'h0, 1'b0, 8'h00, w);
        access(1'b1, 32'h0C, 32'h0, 4'h0, 1'b0, 8'h00, w);
        check_counts("byte_en");

        // Read granted the cycle after a write to the same word.
        access(1'b0, 32'h14, 32'h600DF00D, 4'hF, 1'b0, 8'h00, w);
        access(1'b1, 32'h14, 32'h0, 4'h0, 1'b0, 8'h00, w);

        // Out of range: read returns OOR_RDATA, write leaves mem[0] alone.
        access(1'b0, 32'h0, 32'h01020304, 4'hF, 1'b0, 8'h00, w);
        check_counts("pre_oor");
        access(1'b1, 32'h1000, 32'h0, 4'h0, 1'b0, 8'h00, w);
        access(1'b0, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 8'h00, w);
        access(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 8'h00, w);
        check_counts("oor");

        // enable_i=0 blocks grant for the masked cycles.
        access(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 8'hFF, w);
`ifndef HWPE_TCDM_RESPONDER_RANDOM_STALL_EN
        chk("lat0_enable_off_waits", w, 8);
`endif

        // Clear: control state zeroed, memory kept.
        idle(1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        model_clear();
        check_counts("clear");
        access(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 8'h00, w);
        check_counts("after_clear");

        // GNT_LATENCY=3 instance.
        idle(2);
        sel = 1'b1;
        idle(1);
        access(1'b0, 32'h20, 32'h87654321, 4'hF, 1'b0, 8'h00, w);
`ifndef HWPE_TCDM_RESPONDER_RANDOM_STALL_EN
        chk("lat3_waits", w, 3);
`endif
        access(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 8'h00, w);
`ifndef HWPE_TCDM_RESPONDER_RANDOM_STALL_EN
        chk("lat3_back_to_back_waits", w, 3);
`endif
        access(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 8'b0000_0110, w);
`ifndef HWPE_TCDM_RESPONDER_RANDOM_STALL_EN
        chk("lat3_enable_gap_waits", w, 5);
`endif
        check_counts("lat3");

        // Random traffic on both instances.
        rand_phase(600);
        check_counts("rand_lat3");
        idle(2);
        sel = 1'b0;
        idle(1);
        rand_phase(1500);
        check_counts("rand_lat0");
`ifdef HWPE_TCDM_RESPONDER_RANDOM_STALL_EN
        chk("random_stall_seen", {31'b0, stall_cnt > 0}, 32'h1);
`endif

        // Reset in the cycle after a read handshake.
        access(1'b0, 32'h40, 32'h5A5A5A5A, 4'hF, 1'b0, 8'h00, w);
        access(1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 8'h00, w);
        rst = 1'b1;
        model_reset();
        idle(1);
        rst = 1'b0;
        idle(1);
        check_counts("mid_rst");
        chk("mid_rst_nbr3", nbr3, 0);
        access(1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 8'h00, w);
        access(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 8'h00, w);
        idle(2);
        check_counts("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
